// File: rtl/count_enable_conditioner_pkg.sv
// Shared definitions for the count-enable conditioner: FSM state encodings,
// default timing parameters and the smallest legal values of each.
package count_enable_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_HELD         = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 256;
  localparam int DEF_REPEAT_PERIOD   = 64;

  // Below these values pulse_out could be high on back-to-back cycles.
  localparam int MIN_DEBOUNCE_CYCLES = 2;
  localparam int MIN_REPEAT_DELAY    = 2;
  localparam int MIN_REPEAT_PERIOD   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/count_enable_conditioner_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser with asynchronous active-high clear.
// Generic; intended for reuse on any asynchronous ui_in pin.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/count_enable_conditioner.sv
// count_enable_conditioner: turns a raw bouncing push-button into exactly one
// single-cycle count-enable pulse per accepted press, plus a debounced level
// and the FSM state for debug.
// Optional feature macro: COUNT_ENABLE_AUTO_REPEAT_EN -- while the button stays
// held, extra pulses after REPEAT_DELAY cycles and then every REPEAT_PERIOD.
// Note: rst_n is active-HIGH (1 = reset) despite its name.
module count_enable_conditioner
  import count_enable_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       pulse_out,
  output logic       level_out,
  output logic [1:0] state_out
);

  // Counter only ever holds 0..DEBOUNCE_CYCLES-1, so it cannot wrap.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             s2;
  logic             rep_fire;

  sync_2ff u_sync (
    .clk (clk),
    .clr (rst_n),
    .d   (btn_in),
    .q   (s2)
  );

`ifdef COUNT_ENABLE_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rcnt;
  logic             rep_phase;  // 0: waiting out the initial delay, 1: periodic

  assign rep_fire = (state == ST_HELD) && s2 &&
                    (rcnt == (rep_phase ? PERIOD_LAST : DELAY_LAST));

  // Repeat timer: runs only while HELD is kept, so every HELD entry starts at zero.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end else if (state == ST_HELD && s2) begin
      if (rep_fire) begin
        rcnt      <= '0;
        rep_phase <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end else begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end
  end
`else
  // Repeat disabled: the repeat parameters only feed a constant-false tie-off.
  assign rep_fire = 1'b0 & (REPEAT_DELAY >= MIN_REPEAT_DELAY)
                         & (REPEAT_PERIOD >= MIN_REPEAT_PERIOD);
`endif

  assign state_out = state;

  // Debounce FSM: a level change needs DEBOUNCE_CYCLES+1 stable samples of s2.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pulse_out <= 1'b0;
      level_out <= 1'b0;
    end else begin
      pulse_out <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (s2) begin
            state <= ST_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s2) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_HELD;
            cnt       <= '0;
            pulse_out <= 1'b1;
            level_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!s2) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= '0;
          end else if (rep_fire) begin
            pulse_out <= 1'b1;
          end
        end
        ST_RELEASE_WAIT: begin
          if (s2) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
